// File: rtl/execute_muldiv.sv
// rtl/execute_muldiv.sv - multi-cycle RV32M/RV64M multiply/divide execute unit
// Multiply over MUL_LAT cycles, restoring radix-2 divide, result held until write-back accepts.
module execute_muldiv #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [TAG_W-1:0] tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  rd_data,
  output logic [TAG_W-1:0] rd_tag,
  output logic             busy
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_op;
  logic [XLEN-1:0]  r_a;
  logic [XLEN-1:0]  r_b;
  logic [XLEN-1:0]  r_rem;
  logic             r_q_neg;
  logic             r_r_neg;
  logic [XLEN-1:0]  r_rd_data;
  logic [TAG_W-1:0] r_rd_tag;

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign rd_data   = r_rd_data;
  assign rd_tag    = r_rd_tag;

  logic w_idle;
  logic w_accept;
  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = in_valid && w_idle && !flush;

  // The multiplier reads the live inputs in IDLE so MUL_LAT=1 can finish on the accept edge.
  logic [1:0]             w_m_op;
  logic [XLEN-1:0]        w_m_a;
  logic [XLEN-1:0]        w_m_b;
  logic                   w_a_sgn;
  logic                   w_b_sgn;
  logic signed [XLEN:0]   w_ma;
  logic signed [XLEN:0]   w_mb;
  logic [2*XLEN-1:0]      w_prod;
  logic [XLEN-1:0]        w_mul_res;

  assign w_m_op    = w_idle ? op[1:0] : r_op;
  assign w_m_a     = w_idle ? rs1 : r_a;
  assign w_m_b     = w_idle ? rs2 : r_b;
  assign w_a_sgn   = (w_m_op == 2'b01) || (w_m_op == 2'b10);
  assign w_b_sgn   = (w_m_op == 2'b01);
  assign w_ma      = {w_a_sgn & w_m_a[XLEN-1], w_m_a};
  assign w_mb      = {w_b_sgn & w_m_b[XLEN-1], w_m_b};
  assign w_prod    = (2*XLEN)'(w_ma) * (2*XLEN)'(w_mb);
  assign w_mul_res = (w_m_op == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  logic            w_d_signed;
  logic            w_div_zero;
  logic            w_ovf;
  logic [XLEN-1:0] w_spec_res;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;

  assign w_d_signed = ~op[0];
  assign w_div_zero = (rs2 == '0);
  assign w_ovf      = w_d_signed && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
  assign w_spec_res = w_div_zero ? (op[1] ? rs1 : '1) : (op[1] ? '0 : rs1);
  assign w_abs_a    = (w_d_signed && rs1[XLEN-1]) ? -rs1 : rs1;
  assign w_abs_b    = (w_d_signed && rs2[XLEN-1]) ? -rs2 : rs2;

  // One restoring step: r_a shifts dividend bits out and quotient bits in.
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_nx;
  logic [XLEN-1:0] w_quo_nx;
  logic [XLEN-1:0] w_quo_fix;
  logic [XLEN-1:0] w_rem_fix;

  assign w_shift   = {r_rem, r_a[XLEN-1]};
  assign w_diff    = w_shift - {1'b0, r_b};
  assign w_ge      = ~w_diff[XLEN];
  assign w_rem_nx  = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_quo_nx  = {r_a[XLEN-2:0], w_ge};
  assign w_quo_fix = r_q_neg ? -w_quo_nx : w_quo_nx;
  assign w_rem_fix = r_r_neg ? -w_rem_nx : w_rem_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_rem     <= '0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_rd_data <= '0;
      r_rd_tag  <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op     <= op[1:0];
            r_rd_tag <= tag;
            if (!op[2]) begin
              r_a   <= rs1;
              r_b   <= rs2;
              r_cnt <= CW'(MUL_LAT - 1);
              if (MUL_LAT == 1) begin
                r_rd_data <= w_mul_res;
                r_state   <= S_DONE;
              end else begin
                r_state <= S_MUL;
              end
            end else if (w_div_zero || w_ovf) begin
              r_rd_data <= w_spec_res;
              r_state   <= S_DONE;
            end else begin
              r_a     <= w_abs_a;
              r_b     <= w_abs_b;
              r_rem   <= '0;
              r_q_neg <= w_d_signed && (rs1[XLEN-1] ^ rs2[XLEN-1]);
              r_r_neg <= w_d_signed && rs1[XLEN-1];
              r_cnt   <= CW'(XLEN);
              r_state <= S_DIV;
            end
          end
        end
        S_MUL: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          if (r_cnt <= CW'(1)) begin
            r_rd_data <= w_mul_res;
            r_state   <= S_DONE;
          end
        end
        S_DIV: begin
          r_a   <= w_quo_nx;
          r_rem <= w_rem_nx;
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          if (r_cnt <= CW'(1)) begin
            r_rd_data <= r_op[1] ? w_rem_fix : w_quo_fix;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_muldiv.sv
// tb/tb_execute_muldiv.sv - scoreboard bench for execute_muldiv in 32/2 and 64/1 configurations
// Stimulus pushes expected results; a negedge monitor pops and compares on each new out_valid.
module tb_execute_muldiv;

  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  tag;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [1:0]  in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [2:0]  op [2];
  logic [63:0] rs1 [2];
  logic [63:0] rs2 [2];
  logic [4:0]  tag [2];
  logic [4:0]  rd_tag [2];
  logic [31:0] rd32;
  logic [63:0] rd64;

  exp_t q0[$];
  exp_t q1[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   acc, h, n;
  bit          seen [2];
  logic [63:0] held [2];

  execute_muldiv #(.XLEN(32), .MUL_LAT(2), .TAG_W(5)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .op(op[0]),
    .rs1(rs1[0][31:0]), .rs2(rs2[0][31:0]), .tag(tag[0]), .flush(flush[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .rd_data(rd32), .rd_tag(rd_tag[0]),
    .busy(busy[0])
  );

  execute_muldiv #(.XLEN(64), .MUL_LAT(1), .TAG_W(5)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .op(op[1]),
    .rs1(rs1[1]), .rs2(rs2[1]), .tag(tag[1]), .flush(flush[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .rd_data(rd64), .rd_tag(rd_tag[1]),
    .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] rd_of(input int c);
    return (c == 0) ? {32'd0, rd32} : rd64;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int c = 0; c < 2; c++) begin
        if (out_valid[c] && !seen[c]) begin
          if ((c == 0 && q0.size() == 0) || (c == 1 && q1.size() == 0)) begin
            check($sformatf("cfg%0d_unexpected_out_valid", c), 64'd1, 64'd0);
          end else begin
            if (c == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            check($sformatf("cfg%0d_rd_data", c), rd_of(c), e.data);
            check($sformatf("cfg%0d_rd_tag", c), 64'(rd_tag[c]), 64'(e.tag));
            check($sformatf("cfg%0d_latency", c), 64'(cyc), 64'(e.cyc));
          end
          held[c] = rd_of(c);
        end else if (out_valid[c]) begin
          check($sformatf("cfg%0d_rd_hold", c), rd_of(c), held[c]);
        end
        seen[c] = out_valid[c];
      end
    end
  end

  task automatic issue(input int c, input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] t, input logic [63:0] exp, input int lat, input bit push,
                       output int acc_cyc);
    exp_t e;
    bit   got = 1'b0;
    op[c] = o; rs1[c] = a; rs2[c] = b; tag[c] = t; in_valid[c] = 1'b1;
    acc_cyc = -1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = in_ready[c];
    end
    if (!got) begin
      check("accept_timeout", 64'd0, 64'd1);
    end else begin
      acc_cyc = cyc;
      if (push) begin
        e.data = exp; e.tag = t; e.cyc = cyc + lat;
        if (c == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
    end
    @(posedge clk); #1;
    in_valid[c] = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((q0.size() != 0 || q1.size() != 0 || out_valid != 2'b00) && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 3000) check("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = '0; flush = '0; out_ready = 2'b11;
    for (int c = 0; c < 2; c++) begin
      op[c] = '0; rs1[c] = '0; rs2[c] = '0; tag[c] = '0; seen[c] = 1'b0; held[c] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      check($sformatf("cfg%0d_rst_in_ready", c), 64'(in_ready[c]), 64'd1);
      check($sformatf("cfg%0d_rst_out_valid", c), 64'(out_valid[c]), 64'd0);
      check($sformatf("cfg%0d_rst_busy", c), 64'(busy[c]), 64'd0);
      check($sformatf("cfg%0d_rst_rd_data", c), rd_of(c), 64'd0);
      check($sformatf("cfg%0d_rst_rd_tag", c), 64'(rd_tag[c]), 64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // XLEN=32, MUL_LAT=2
    issue(0, OP_MUL,    64'h7,        64'hFFFFFFFD, 5'd1,  64'hFFFFFFEB, 2,  1, acc);
    issue(0, OP_MULH,   64'h80000000, 64'h80000000, 5'd2,  64'h40000000, 2,  1, acc);
    issue(0, OP_MULHU,  64'hFFFFFFFF, 64'hFFFFFFFF, 5'd3,  64'hFFFFFFFE, 2,  1, acc);
    issue(0, OP_MULHSU, 64'hFFFFFFFF, 64'h2,        5'd4,  64'hFFFFFFFF, 2,  1, acc);
    issue(0, OP_DIV,    64'hFFFFFFF9, 64'h2,        5'd5,  64'hFFFFFFFD, 33, 1, acc);
    issue(0, OP_REM,    64'hFFFFFFF9, 64'h2,        5'd6,  64'hFFFFFFFF, 33, 1, acc);
    issue(0, OP_DIV,    64'h7,        64'hFFFFFFFE, 5'd7,  64'hFFFFFFFD, 33, 1, acc);
    issue(0, OP_REM,    64'h7,        64'hFFFFFFFE, 5'd8,  64'h1,        33, 1, acc);
    issue(0, OP_DIVU,   64'h5,        64'h0,        5'd9,  64'hFFFFFFFF, 1,  1, acc);
    issue(0, OP_REMU,   64'h5,        64'h0,        5'd10, 64'h5,        1,  1, acc);
    issue(0, OP_DIV,    64'h80000000, 64'hFFFFFFFF, 5'd11, 64'h80000000, 1,  1, acc);
    issue(0, OP_REM,    64'h80000000, 64'hFFFFFFFF, 5'd12, 64'h0,        1,  1, acc);
    drain();

    // Backpressure in DONE, then immediate re-accept
    out_ready[0] = 1'b0;
    issue(0, OP_DIVU, 64'd100, 64'd7, 5'd13, 64'd14, 33, 1, acc);
    n = 0;
    while (!out_valid[0] && n < 100) begin @(negedge clk); n++; end
    check("bp_out_valid_seen", 64'(out_valid[0]), 64'd1);
    repeat (5) begin
      check("bp_in_ready_low", 64'(in_ready[0]), 64'd0);
      @(negedge clk);
    end
    check("bp_in_ready_hs", 64'(in_ready[0]), 64'd0);
    out_ready[0] = 1'b1;
    h = cyc;
    @(posedge clk); #1;
    issue(0, OP_REMU, 64'd100, 64'd7, 5'd14, 64'd2, 33, 1, acc);
    check("bp_accept_cycle", 64'(acc), 64'(h + 1));
    drain();

    // Flush mid-divide, then flush coincident with in_valid
    issue(0, OP_DIV, 64'd1000, 64'd3, 5'd15, 64'd0, 0, 0, acc);
    repeat (9) @(posedge clk);
    #1 flush[0] = 1'b1;
    @(posedge clk); #1;
    flush[0] = 1'b0;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready[0]), 64'd1);
    check("flush_busy", 64'(busy[0]), 64'd0);
    check("flush_out_valid", 64'(out_valid[0]), 64'd0);
    repeat (40) @(posedge clk);
    #1;
    op[0] = OP_MUL; rs1[0] = 64'd3; rs2[0] = 64'd3; in_valid[0] = 1'b1; flush[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0; flush[0] = 1'b0;
    @(negedge clk);
    check("flush_accept_busy", 64'(busy[0]), 64'd0);
    check("flush_accept_in_ready", 64'(in_ready[0]), 64'd1);
    @(posedge clk); #1;

    // Reset mid-multiply
    issue(0, OP_MUL, 64'd3, 64'd5, 5'd16, 64'd0, 0, 0, acc);
    @(negedge clk);
    check("mul_busy", 64'(busy[0]), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mul_in_ready", 64'(in_ready[0]), 64'd1);
    check("rst_mul_out_valid", 64'(out_valid[0]), 64'd0);
    check("rst_mul_rd_data", rd_of(0), 64'd0);
    @(posedge clk); #1;

    // XLEN=64, MUL_LAT=1
    issue(1, OP_MUL,   64'd7, 64'hFFFFFFFFFFFFFFFD, 5'd1, 64'hFFFFFFFFFFFFFFEB, 1, 1, acc);
    issue(1, OP_MULH,  64'h8000000000000000, 64'h8000000000000000, 5'd2, 64'h4000000000000000, 1, 1, acc);
    issue(1, OP_MULHU, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 5'd3, 64'hFFFFFFFFFFFFFFFE, 1, 1, acc);
    issue(1, OP_DIV,   64'hFFFFFFFFFFFFFFF9, 64'd2, 5'd4, 64'hFFFFFFFFFFFFFFFD, 65, 1, acc);
    issue(1, OP_REM,   64'hFFFFFFFFFFFFFFF9, 64'd2, 5'd5, 64'hFFFFFFFFFFFFFFFF, 65, 1, acc);
    issue(1, OP_DIVU,  64'd100, 64'd7, 5'd6, 64'd14, 65, 1, acc);
    issue(1, OP_REMU,  64'd100, 64'd7, 5'd7, 64'd2,  65, 1, acc);
    issue(1, OP_DIVU,  64'hFFFFFFFFFFFFFFFF, 64'h100000000, 5'd8, 64'hFFFFFFFF, 65, 1, acc);
    issue(1, OP_REMU,  64'hFFFFFFFFFFFFFFFF, 64'h100000000, 5'd9, 64'hFFFFFFFF, 65, 1, acc);
    issue(1, OP_DIVU,  64'd5, 64'd0, 5'd10, 64'hFFFFFFFFFFFFFFFF, 1, 1, acc);
    issue(1, OP_REM,   64'd5, 64'd0, 5'd11, 64'd5, 1, 1, acc);
    issue(1, OP_DIV,   64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 5'd12, 64'h8000000000000000, 1, 1, acc);
    issue(1, OP_REM,   64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 5'd13, 64'd0, 1, 1, acc);
    drain();

    // Reset mid-divide
    issue(1, OP_DIV, 64'd1000, 64'd7, 5'd14, 64'd0, 0, 0, acc);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_div_in_ready", 64'(in_ready[1]), 64'd1);
    check("rst_div_out_valid", 64'(out_valid[1]), 64'd0);
    check("rst_div_rd_data", rd_of(1), 64'd0);
    repeat (80) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
